// File: rtl/mfi_retire_tracer.sv
// mfi_retire_tracer: holds each commit until its successor PC is known, then emits one MFI trace entry
module mfi_retire_tracer #(
  parameter int XLEN = 64,
  parameter int ORDER_W = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               commit_valid,
  input  logic [XLEN-1:0]    commit_pc,
  input  logic [31:0]        commit_insn,
  input  logic               commit_trap,
  input  logic               commit_halt,
  input  logic [4:0]         commit_rd_addr,
  input  logic [XLEN-1:0]    commit_rd_wdata,
  input  logic               drain_valid,
  input  logic [XLEN-1:0]    drain_pc,
  output logic               mfi_valid,
  output logic [ORDER_W-1:0] mfi_order,
  output logic [31:0]        mfi_insn,
  output logic               mfi_trap,
  output logic               mfi_halt,
  output logic [4:0]         mfi_rd_addr,
  output logic [XLEN-1:0]    mfi_rd_wdata,
  output logic [XLEN-1:0]    mfi_pc_rdata,
  output logic [XLEN-1:0]    mfi_pc_wdata
);
  localparam logic [1:0] EMPTY = 2'd0, HELD = 2'd1, HELD_DRAINED = 2'd2, HALTED = 2'd3;
  logic [1:0] state, state_next;
  logic [XLEN-1:0] p_pc, p_rd_wdata, latched_pc, wdata, in_rd_wdata;
  logic [31:0] p_insn;
  logic p_trap, p_halt;
  logic [4:0] p_rd_addr;
  logic [ORDER_W-1:0] next_order;
  logic emit, emit_pending, load, latch;
  assign in_rd_wdata = commit_rd_addr == 5'd0 ? '0 : commit_rd_wdata;
  // Decide what to emit, what to capture into the pending entry, and the next state
  always_comb begin
    state_next = state;
    emit = 1'b0;
    emit_pending = 1'b1;
    load = 1'b0;
    latch = 1'b0;
    wdata = commit_pc;
    case (state)
      EMPTY: if (commit_valid) begin
        if (drain_valid) begin
          emit = 1'b1;
          emit_pending = 1'b0;
          wdata = drain_pc;
          state_next = commit_halt ? HALTED : EMPTY;
        end else begin
          load = 1'b1;
          state_next = HELD;
        end
      end
      HELD: if (commit_valid) begin
        emit = 1'b1;
        wdata = commit_pc;
        if (p_halt) state_next = HALTED;
        else begin
          load = 1'b1;
          latch = drain_valid;
          state_next = drain_valid ? HELD_DRAINED : HELD;
        end
      end else if (drain_valid) begin
        emit = 1'b1;
        wdata = drain_pc;
        state_next = p_halt ? HALTED : EMPTY;
      end
      HELD_DRAINED: begin
        emit = 1'b1;
        wdata = latched_pc;
        if (p_halt) state_next = HALTED;
        else if (commit_valid) begin
          load = 1'b1;
          latch = drain_valid;
          state_next = drain_valid ? HELD_DRAINED : HELD;
        end else state_next = EMPTY;
      end
      default: ;
    endcase
  end
  // Register state, the pending entry, the order counter and the trace outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= EMPTY;
      p_pc <= '0;
      p_insn <= '0;
      p_trap <= 1'b0;
      p_halt <= 1'b0;
      p_rd_addr <= '0;
      p_rd_wdata <= '0;
      latched_pc <= '0;
      next_order <= '0;
      mfi_valid <= 1'b0;
      mfi_order <= '0;
      mfi_insn <= '0;
      mfi_trap <= 1'b0;
      mfi_halt <= 1'b0;
      mfi_rd_addr <= '0;
      mfi_rd_wdata <= '0;
      mfi_pc_rdata <= '0;
      mfi_pc_wdata <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        p_pc <= commit_pc;
        p_insn <= commit_insn;
        p_trap <= commit_trap;
        p_halt <= commit_halt;
        p_rd_addr <= commit_rd_addr;
        p_rd_wdata <= in_rd_wdata;
      end
      if (latch) latched_pc <= drain_pc;
      mfi_valid <= emit;
      if (emit) begin
        next_order <= next_order + ORDER_W'(1);
        mfi_order <= next_order;
        mfi_insn <= emit_pending ? p_insn : commit_insn;
        mfi_trap <= emit_pending ? p_trap : commit_trap;
        mfi_halt <= emit_pending ? p_halt : commit_halt;
        mfi_rd_addr <= emit_pending ? p_rd_addr : commit_rd_addr;
        mfi_rd_wdata <= emit_pending ? p_rd_wdata : in_rd_wdata;
        mfi_pc_rdata <= emit_pending ? p_pc : commit_pc;
        mfi_pc_wdata <= wdata;
      end
    end
  end
endmodule

// File: tb/tb_mfi_retire_tracer.sv
// tb_mfi_retire_tracer: scoreboard bench for the MFI retirement tracer
module tb_mfi_retire_tracer;
  logic clock = 1'b0, reset = 1'b1;
  logic commit_valid = 1'b0, commit_trap = 1'b0, commit_halt = 1'b0, drain_valid = 1'b0;
  logic [63:0] commit_pc = '0, commit_rd_wdata = '0, drain_pc = '0;
  logic [31:0] commit_insn = '0;
  logic [4:0] commit_rd_addr = '0;
  logic mfi_valid, mfi_trap, mfi_halt;
  logic [3:0] mfi_order;
  logic [31:0] mfi_insn;
  logic [4:0] mfi_rd_addr;
  logic [63:0] mfi_rd_wdata, mfi_pc_rdata, mfi_pc_wdata;
  typedef struct {
    logic [3:0] order;
    logic [63:0] rdata, wdata, wd;
    logic [31:0] insn;
    logic trap, halt;
    logic [4:0] rd;
  } ent_t;
  ent_t sb[$];
  logic [3:0] exp_order;
  int checks = 0, errors = 0, n_emit = 0;
  mfi_retire_tracer #(.XLEN(64), .ORDER_W(4)) dut (
    .clock(clock), .reset(reset), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_insn(commit_insn), .commit_trap(commit_trap), .commit_halt(commit_halt),
    .commit_rd_addr(commit_rd_addr), .commit_rd_wdata(commit_rd_wdata),
    .drain_valid(drain_valid), .drain_pc(drain_pc), .mfi_valid(mfi_valid),
    .mfi_order(mfi_order), .mfi_insn(mfi_insn), .mfi_trap(mfi_trap), .mfi_halt(mfi_halt),
    .mfi_rd_addr(mfi_rd_addr), .mfi_rd_wdata(mfi_rd_wdata), .mfi_pc_rdata(mfi_pc_rdata),
    .mfi_pc_wdata(mfi_pc_wdata)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] insn_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'ha5a5_0013;
  endfunction
  task automatic expect_ent(input logic [63:0] rdata, input logic [63:0] wdata, input logic trap,
                            input logic halt, input logic [4:0] rd, input logic [63:0] wd);
    ent_t e;
    e.order = exp_order;
    e.rdata = rdata;
    e.wdata = wdata;
    e.insn = insn_of(rdata);
    e.trap = trap;
    e.halt = halt;
    e.rd = rd;
    e.wd = wd;
    sb.push_back(e);
    exp_order = exp_order + 4'd1;
  endtask
  task automatic cyc(input logic v, input logic [63:0] pc, input logic trap, input logic halt,
                     input logic [4:0] rd, input logic [63:0] wd, input logic dv, input logic [63:0] dpc);
    commit_valid = v;
    commit_pc = pc;
    commit_insn = insn_of(pc);
    commit_trap = trap;
    commit_halt = halt;
    commit_rd_addr = rd;
    commit_rd_wdata = wd;
    drain_valid = dv;
    drain_pc = dpc;
    @(posedge clock);
    #1;
  endtask
  task automatic c(input logic [63:0] pc);
    cyc(1'b1, pc, 1'b0, 1'b0, 5'd1, pc + 64'd7, 1'b0, 64'd0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 64'd0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    exp_order = 4'd0;
  endtask
  // Pop one expected entry per observed trace entry and compare all fields
  always @(negedge clock) begin
    if (!reset && mfi_valid) begin
      n_emit++;
      if (sb.size() == 0) check("unexpected_entry", 64'd1, 64'd0);
      else begin
        ent_t e;
        e = sb.pop_front();
        check("order", 64'(mfi_order), 64'(e.order));
        check("pc_rdata", mfi_pc_rdata, e.rdata);
        check("pc_wdata", mfi_pc_wdata, e.wdata);
        check("insn", 64'(mfi_insn), 64'(e.insn));
        check("trap", 64'(mfi_trap), 64'(e.trap));
        check("halt", 64'(mfi_halt), 64'(e.halt));
        check("rd_addr", 64'(mfi_rd_addr), 64'(e.rd));
        check("rd_wdata", mfi_rd_wdata, e.wd);
      end
    end
  end
  initial begin
    int base;
    exp_order = 4'd0;
    idle(2);
    check("rst_valid", 64'(mfi_valid), 64'd0);
    check("rst_order", 64'(mfi_order), 64'd0);
    check("rst_wdata", mfi_pc_wdata, 64'd0);
    check("rst_rdata", mfi_pc_rdata, 64'd0);
    reset = 1'b0;
    c(64'h100);
    expect_ent(64'h100, 64'h104, 1'b0, 1'b0, 5'd1, 64'h107);
    c(64'h104);
    expect_ent(64'h104, 64'h108, 1'b0, 1'b0, 5'd1, 64'h10b);
    c(64'h108);
    idle(4);
    check("seq_count", 64'(n_emit), 64'd2);
    check("seq_drained", 64'(sb.size()), 64'd0);
    do_reset();
    idle(2);
    check("reset_discard", 64'(n_emit), 64'd2);
    c(64'h200);
    expect_ent(64'h200, 64'h340, 1'b0, 1'b0, 5'd1, 64'h207);
    c(64'h340);
    expect_ent(64'h340, 64'h80, 1'b0, 1'b0, 5'd1, 64'h347);
    cyc(1'b0, 64'd0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 64'h80);
    idle(2);
    expect_ent(64'h400, 64'h404, 1'b0, 1'b0, 5'd2, 64'h55);
    cyc(1'b1, 64'h400, 1'b0, 1'b0, 5'd2, 64'h55, 1'b1, 64'h404);
    check("empty_lat1_valid", 64'(mfi_valid), 64'd1);
    idle(2);
    c(64'h10);
    expect_ent(64'h10, 64'h14, 1'b0, 1'b0, 5'd1, 64'h17);
    cyc(1'b1, 64'h14, 1'b0, 1'b0, 5'd3, 64'h99, 1'b1, 64'h1000);
    check("coin_c1_valid", 64'(mfi_valid), 64'd1);
    check("coin_c1_rdata", mfi_pc_rdata, 64'h10);
    expect_ent(64'h14, 64'h1000, 1'b0, 1'b0, 5'd3, 64'h99);
    idle(1);
    check("coin_c2_valid", 64'(mfi_valid), 64'd1);
    check("coin_c2_rdata", mfi_pc_rdata, 64'h14);
    idle(1);
    check("coin_c3_valid", 64'(mfi_valid), 64'd0);
    cyc(1'b1, 64'h30, 1'b0, 1'b0, 5'd0, 64'hdead, 1'b0, 64'd0);
    expect_ent(64'h30, 64'h34, 1'b0, 1'b0, 5'd0, 64'd0);
    cyc(1'b1, 64'h34, 1'b1, 1'b0, 5'd5, 64'hbeef, 1'b0, 64'd0);
    expect_ent(64'h34, 64'h800, 1'b1, 1'b0, 5'd5, 64'hbeef);
    cyc(1'b0, 64'd0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 64'h800);
    idle(2);
    check("pre_halt_drained", 64'(sb.size()), 64'd0);
    base = n_emit;
    c(64'h20);
    cyc(1'b0, 64'd0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0);
    cyc(1'b1, 64'h20, 1'b0, 1'b1, 5'd1, 64'h27, 1'b0, 64'd0);
    expect_ent(64'h20, 64'h20, 1'b0, 1'b0, 5'd1, 64'h27);
    expect_ent(64'h20, 64'h24, 1'b0, 1'b1, 5'd1, 64'h27);
    cyc(1'b0, 64'd0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 64'h24);
    c(64'h28);
    c(64'h2c);
    cyc(1'b1, 64'h30, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 64'h34);
    idle(3);
    check("halt_valid_low", 64'(mfi_valid), 64'd0);
    check("halt_count", 64'(n_emit - base), 64'd2);
    do_reset();
    base = n_emit;
    c(64'h50);
    cyc(1'b1, 64'h54, 1'b0, 1'b1, 5'd1, 64'h5b, 1'b0, 64'd0);
    expect_ent(64'h50, 64'h54, 1'b0, 1'b0, 5'd1, 64'h57);
    expect_ent(64'h54, 64'h58, 1'b0, 1'b1, 5'd1, 64'h5b);
    c(64'h58);
    c(64'h5c);
    idle(3);
    check("proto_err_count", 64'(n_emit - base), 64'd2);
    do_reset();
    base = n_emit;
    for (int i = 0; i < 17; i++) begin
      c(64'h1000 + 64'(4 * i));
      if (i > 0) expect_ent(64'h1000 + 64'(4 * (i - 1)), 64'h1000 + 64'(4 * i), 1'b0, 1'b0, 5'd1,
                            64'h1000 + 64'(4 * (i - 1)) + 64'd7);
    end
    expect_ent(64'h1040, 64'h2000, 1'b0, 1'b0, 5'd1, 64'h1047);
    cyc(1'b0, 64'd0, 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 64'h2000);
    idle(3);
    check("wrap_count", 64'(n_emit - base), 64'd17);
    check("wrap_last_order", 64'(mfi_order), 64'd0);
    check("leftover", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mfi_retire_tracer.md
# mfi_retire_tracer

Core-side producer of the MFI retirement trace consumed by the formal checkers (PC-forward, register, order checks). It takes in-order commit events from the writeback stage and assigns consecutive `mfi_order` values. Each instruction is held for one commit so that its `mfi_pc_wdata` equals the PC of the next committed instruction, or the drain PC on trap or halt. All MFI outputs are registered and pulse for one cycle per retired instruction.

## Interface
- `XLEN`, default 64: width of PC and register data.
- `ORDER_W`, default 64: width of `mfi_order`.
- `clock`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `commit_valid`, in, 1: one instruction commits this cycle.
- `commit_pc`, in, XLEN: PC of the committing instruction.
- `commit_insn`, in, 32: instruction word.
- `commit_trap`, in, 1: instruction trapped.
- `commit_halt`, in, 1: last instruction of the trace.
- `commit_rd_addr`, in, 5: destination register; 0 if none.
- `commit_rd_wdata`, in, XLEN: destination write data; forced to 0 when rd_addr = 0.
- `drain_valid`, in, 1: the successor of the newest commit is not a commit. Used for a trap vector or halt.
- `drain_pc`, in, XLEN: next PC for the newest committed instruction.
- `mfi_valid`, out, 1: trace entry valid.
- `mfi_order`, out, ORDER_W: retirement index.
- `mfi_insn`, out, 32: traced fields, copied from the commit.
- `mfi_trap`, out, 1: traced field, copied from the commit.
- `mfi_halt`, out, 1: traced field, copied from the commit.
- `mfi_rd_addr`, out, 5: traced field, copied from the commit.
- `mfi_rd_wdata`, out, XLEN: traced field, copied from the commit.
- `mfi_pc_rdata`, out, XLEN: PC of the traced instruction.
- `mfi_pc_wdata`, out, XLEN: PC of its successor.

## Operation
- **State**
  - FSM states: EMPTY, HELD, HELD_DRAINED, HALTED.
  - One pending-entry register holds all commit fields.
  - `latched_pc` (XLEN).
  - `next_order` counter (ORDER_W).
- **EMPTY**
  - `commit_valid` & !`drain_valid`: load the pending entry and go to HELD. No output.
  - `commit_valid` & `drain_valid`: emit the commit directly with pc_wdata = `drain_pc`. Go to HALTED if `commit_halt`, else stay in EMPTY.
  - `drain_valid` alone: ignored.
- **HELD**
  - `commit_valid` & !`drain_valid`: emit the pending entry with pc_wdata = `commit_pc`, then load the new commit. Stay in HELD.
  - `commit_valid` & `drain_valid`: emit the pending entry with pc_wdata = `commit_pc`, load the new commit, and set `latched_pc` = `drain_pc`. Go to HELD_DRAINED.
  - `drain_valid` alone: emit the pending entry with pc_wdata = `drain_pc`. Go to EMPTY, or to HALTED if the pending entry has halt set.
  - A pending entry with halt set that receives a commit (not a drain) is a protocol error. It is still emitted normally; the FSM goes to HALTED and the new commit is dropped.
- **HELD_DRAINED**
  - Emit the pending entry with pc_wdata = `latched_pc` unconditionally.
  - If `commit_valid` in the same cycle, it is handled as in EMPTY: it goes to the pending register, or is emitted next cycle if `drain_valid` is also set.
  - If the drained entry had halt set, go to HALTED and drop any commit.
- **HALTED**
  - All inputs ignored. `mfi_valid` held at 0 until reset.
- **Ordering**
  - Every emitted entry carries `mfi_order` = `next_order`. `next_order` then increments by 1, wrapping modulo 2^ORDER_W.
  - The first emitted entry after reset has order 0.
  - Orders are gap-free and strictly in commit order.
- **Trap entries** take their pc_wdata from the next commit or drain, exactly like non-trap entries. The core must present the trap vector through `drain_pc` or as the next `commit_pc`.
- **Invariant:** for consecutive emitted entries n and n+1, `pc_wdata(n)` == `pc_rdata(n+1)` unless entry n was drained.

## Timing
- **Reset values:** `mfi_valid` = 0; all other MFI outputs = 0; state EMPTY; `next_order` = 0; `latched_pc` = 0.
- **Reset mid-operation:** the pending entry is discarded without emission. Reset has priority over all inputs.
- **Output register:** MFI outputs update on the clock edge following the triggering input cycle and hold for exactly one cycle. `mfi_valid` is deasserted on the following cycle unless a new entry is emitted.
- **Latency:**
  - Instruction k appears 1 cycle after the cycle in which commit k+1 or its drain arrives.
  - A drain coincident with a commit from EMPTY gives a 1-cycle latency.
  - From HELD, the coincident-drain instruction appears 2 cycles after its commit.
- **Throughput:** at most one entry emitted per cycle. Back-to-back commits every cycle produce back-to-back MFI entries with no bubbles.
- **No ready/backpressure.** The consumer samples every cycle.

## Test plan
- **Sequential commits:** reset, then commits at PCs 0x100, 0x104, 0x108 on three consecutive cycles. Required: entries order 0 (rdata 0x100, wdata 0x104) and order 1 (rdata 0x104, wdata 0x108); 0x108 stays pending with no third entry.
- **Taken branch and drain:** commit 0x200, commit 0x340, then `drain_valid` with `drain_pc` = 0x80. Required: order 0 with wdata 0x340; order 1 with rdata 0x340, wdata 0x80; FSM returns to EMPTY.
- **Coincident drain in HELD:** pending 0x10; same cycle commit 0x14 with `drain_valid`, `drain_pc` = 0x1000. Required: cycle+1 gives order 0 (0x10→0x14); cycle+2 gives order 1 (0x14→0x1000).
- **Halt:** commit 0x20 with halt, then drain 0x24, then further commits. Required: exactly one entry with `mfi_halt` = 1 and wdata 0x24; `mfi_valid` stays 0 afterwards until reset.
- **Reset mid-operation and rd0 masking:**
  - Pending entry present, then assert reset. Required: no entry emitted; the next trace restarts at order 0.
  - Commit with `rd_addr` = 0 and `rd_wdata` = 0xdead. Required: traced `mfi_rd_wdata` = 0.
- **Order wrap:** with ORDER_W = 4, run 17 sequential commits. Required: orders run 0..15 then 0, and the pc invariant holds across the wrap.
